// File: rtl/sr_pkg.sv
// sr_pkg: shared shift-register path constants and readback FSM state encoding.
package sr_pkg;
  localparam int SR_WIDTH = 170;
  localparam int SR_CNT_W = 8;
  localparam int SR_LAT_W = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } sr_state_t;
endpackage

// File: rtl/sr_deser.sv
// sr_deser: serial-in parallel-out register, new bits enter at the LSB so the first bit ends in the MSB.
module sr_deser import sr_pkg::*; #(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_q <= '0;
    else if (i_en) r_q <= {r_q[WIDTH-2:0], i_din};
  end
  assign o_q = r_q;
endmodule

// File: rtl/sr_readback.sv
// sr_readback: captures the serial readback stream from the chip shift register into a parallel word.
// Optional compare against expect_din is enabled by defining SR_READBACK_COMPARE_EN.
module sr_readback import sr_pkg::*; #(
  parameter int WIDTH   = SR_WIDTH,
  parameter int CNT_W   = SR_CNT_W,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dout_sr,
  input  logic [WIDTH-1:0] expect_din,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             mismatch
);
  sr_state_t r_state, w_next;
  logic [SR_LAT_W-1:0] r_lat;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dout, w_sr;
  logic r_busy, r_valid;
  logic w_accept, w_shift, w_done, w_last_lat, w_last_bit;
  assign w_accept   = (r_state == IDLE) && start;
  assign w_shift    = (r_state == SHIFT);
  assign w_done     = (r_state == DONE);
  assign w_last_lat = (r_lat == SR_LAT_W'(LATENCY - 1));
  assign w_last_bit = (r_count == CNT_W'(WIDTH - 1));
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? ((LATENCY > 0) ? WAIT : SHIFT) : IDLE;
      WAIT:    w_next = w_last_lat ? SHIFT : WAIT;
      SHIFT:   w_next = w_last_bit ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_dout  <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_valid <= w_done;
      r_count <= w_accept ? '0 : (w_shift ? r_count + 1'b1 : r_count);
      r_lat   <= w_accept ? '0 : ((r_state == WAIT) ? r_lat + 1'b1 : r_lat);
      if (w_done) r_dout <= w_sr;
    end
  end
  sr_deser #(.WIDTH(WIDTH)) u_deser (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (w_shift),
    .i_din (dout_sr),
    .o_q   (w_sr)
  );
`ifdef SR_READBACK_COMPARE_EN
  logic [WIDTH-1:0] r_exp;
  logic r_mismatch;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept) r_exp <= expect_din;
      if (w_done) r_mismatch <= (w_sr != r_exp);
    end
  end
  assign mismatch = r_mismatch;
`else
  // expect_din is folded into a constant zero so it stays connected without any storage
  assign mismatch = 1'b0 & (^expect_din);
`endif
  assign busy  = r_busy;
  assign count = r_count;
  assign dout  = r_dout;
  assign valid = r_valid;
endmodule

// File: tb/tb_sr_readback.sv
// tb_sr_readback: table-driven and randomized checks of sr_readback at LATENCY 0 and 3.
module tb_sr_readback;
  localparam int W = 170;
  localparam int CW = 8;
  typedef struct {
    int         sel;
    logic [W-1:0] word;
    logic [W-1:0] expw;
    int         restart_i;
    bit         mm;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_v = '0;
  logic [1:0] busy_v, valid_v, mm_v;
  logic dout_sr = 1'b0;
  logic [W-1:0] expect_din = '0;
  logic [CW-1:0] cnt_v [2];
  logic [W-1:0] dout_v [2];
  int n_tests = 0;
  int n_fail = 0;
  vec_t tbl [6];
  always #5 clk = ~clk;
  sr_readback #(.WIDTH(W), .CNT_W(CW), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dout_sr(dout_sr), .expect_din(expect_din),
    .busy(busy_v[0]), .count(cnt_v[0]), .dout(dout_v[0]), .valid(valid_v[0]), .mismatch(mm_v[0]));
  sr_readback #(.WIDTH(W), .CNT_W(CW), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dout_sr(dout_sr), .expect_din(expect_din),
    .busy(busy_v[1]), .count(cnt_v[1]), .dout(dout_v[1]), .valid(valid_v[1]), .mismatch(mm_v[1]));
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic capture(input int sel, input logic [W-1:0] word, input logic [W-1:0] expw,
                         input int restart_i, input bit mm_en);
    int lat, nb;
    logic b, mm;
    logic [W-1:0] m;
    lat = sel ? 3 : 0;
    nb = 0;
    m = '0;
`ifdef SR_READBACK_COMPARE_EN
    mm = mm_en;
`else
    mm = 1'b0;
`endif
    expect_din = expw;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    expect_din = ~expw;
    chk("busy_rise", busy_v[sel], 1);
    chk("count_clear", cnt_v[sel], 0);
    for (int i = 0; i < lat + W; i++) begin
      b = (i < lat) ? 1'($urandom) : word[W-1-(i-lat)];
      dout_sr = b;
      if (i == restart_i) start_v[sel] = 1'b1;
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
      if (i >= lat) begin
        m[W-1-nb] = b;
        nb++;
      end
      chk("busy_run", busy_v[sel], 1);
      chk("valid_early", valid_v[sel], 0);
      chk("count_run", cnt_v[sel], W'(nb));
    end
    dout_sr = 1'($urandom);
    @(posedge clk); #1;
    chk("valid_pulse", valid_v[sel], 1);
    chk("dout_word", dout_v[sel], m);
    chk("count_final", cnt_v[sel], W);
    chk("busy_fall", busy_v[sel], 0);
    chk("mismatch", mm_v[sel], mm);
    @(posedge clk); #1;
    chk("valid_single", valid_v[sel], 0);
    chk("idle_after", busy_v[sel], 0);
    chk("count_hold", cnt_v[sel], W);
    chk("dout_hold", dout_v[sel], m);
    chk("mismatch_hold", mm_v[sel], mm);
  endtask
  initial begin
    logic [W-1:0] rw, re;
    int first, second, pulses, seen;
    tbl[0] = '{0, W'(11), W'(11), -1, 1'b0};
    tbl[1] = '{1, W'(11), W'(11), -1, 1'b0};
    tbl[2] = '{0, W'(11), W'(11), 50, 1'b0};
    tbl[3] = '{0, W'(10), W'(11), -1, 1'b1};
    tbl[4] = '{1, {W{1'b1}}, {W{1'b1}}, -1, 1'b0};
    tbl[5] = '{0, {85{2'b10}}, '0, -1, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", busy_v[s], 0);
      chk("rst_count", cnt_v[s], 0);
      chk("rst_dout", dout_v[s], 0);
      chk("rst_valid", valid_v[s], 0);
      chk("rst_mismatch", mm_v[s], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int t = 0; t < 6; t++)
      capture(tbl[t].sel, tbl[t].word, tbl[t].expw, tbl[t].restart_i, tbl[t].mm);
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < W; j++) rw[j] = 1'($urandom);
      re = rw;
      if ($urandom_range(0, 1) == 1) re[$urandom_range(0, W-1)] ^= 1'b1;
      capture(int'($urandom_range(0, 1)), rw, re, -1, re != rw);
    end
    first = -1;
    second = -1;
    pulses = 0;
    start_v[0] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      dout_sr = 1'($urandom);
      @(posedge clk); #1;
      if (valid_v[0]) begin
        pulses++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    start_v[0] = 1'b0;
    chk("held_pulses", W'(pulses), 2);
    chk("held_first", W'(first), 171);
    chk("held_gap", W'(second - first), 172);
    for (int i = 0; i < 300 && busy_v[0]; i++) begin
      @(posedge clk); #1;
    end
    chk("held_drain", busy_v[0], 0);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      dout_sr = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("pre_rst_count", cnt_v[0], 80);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", busy_v[0], 0);
    chk("mid_rst_count", cnt_v[0], 0);
    chk("mid_rst_dout", dout_v[0], 0);
    chk("mid_rst_valid", valid_v[0], 0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      dout_sr = 1'($urandom);
      @(posedge clk); #1;
      if (valid_v[0] || busy_v[0]) seen++;
    end
    chk("post_rst_quiet", W'(seen), 0);
    for (int j = 0; j < W; j++) rw[j] = 1'($urandom);
    capture(0, rw, rw, -1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_readback.md
Name: sr_readback

Overview:
- Receive end of the configuration shift-register path.
- After a write/shift sequence is started, the chip shifts its previous contents out serially on dout_sr. This block samples that stream and assembles it into a WIDTH-bit parallel word.
- Sits beside the shift-register write controller, shares its start pulse and clock, and feeds the readback word to the register/compare logic.

Parameters:
- WIDTH, 170, number of shift-register bits to capture.
- CNT_W, 8, width of the bit counter; must satisfy 2**CNT_W > WIDTH.
- LATENCY, 0, number of clk cycles between the accepted start and the first valid serial bit; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  capture request; sampled only in IDLE.
- dout_sr  input  1  serial data returning from the chip shift register.
- expect_din  input  WIDTH  expected word, used only with the optional compare; sampled at accepted start.
- busy  output  1  high from the cycle after an accepted start until DONE exits.
- count  output  CNT_W  number of bits captured so far in the current operation.
- dout  output  WIDTH  last completed readback word.
- valid  output  1  one-cycle pulse when dout is updated.
- mismatch  output  1  compare result for the last completed word (optional feature).

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE.
  - busy=0, count=0, dout=0, valid=0, mismatch=0.
  - Internal shift register and latency counter cleared.
  - Reset overrides everything, including mid-capture; the partial word is discarded and dout is cleared.
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE:
  - start=1 at edge k is accepted.
  - Go to WAIT if LATENCY>0, otherwise to SHIFT.
  - Clear count and the shift register; latch expect_din.
  - start=0 stays in IDLE.
- WAIT:
  - Latency counter counts LATENCY cycles, then goes to SHIFT.
  - dout_sr is ignored in WAIT.
- SHIFT:
  - At each edge, dout_sr is shifted into the internal register LSB side: sr <= {sr[WIDTH-2:0], dout_sr}. The first bit received therefore ends in bit WIDTH-1 (MSB-first, matching transmit order).
  - count increments by 1 per sampled bit.
  - Sample edges are k+1+LATENCY through k+LATENCY+WIDTH inclusive.
  - When count reaches WIDTH-1 and the final bit is sampled, go to DONE.
- DONE (one cycle):
  - dout <= sr, valid=1, count holds WIDTH.
  - Next state IDLE.
  - The first valid pulse is at edge k+LATENCY+WIDTH+1.
- busy:
  - 1 in WAIT, SHIFT and DONE; 0 in IDLE.
  - Registered, so it rises the cycle after the accepted start.
- start while busy: ignored, with no queueing and no restart.
- start held high continuously: a new capture is accepted in the IDLE cycle following DONE, giving back-to-back operations with a 1-cycle IDLE gap.
- Outputs between operations:
  - count holds its final value until the next accepted start.
  - dout holds until the next DONE.
- Width rules: count saturates logically at WIDTH, and no wrap is permitted within an operation.

Optional Feature:
- Macro: SR_READBACK_COMPARE_EN.
- Enabled:
  - In DONE, mismatch <= (sr != latched expect_din), updated together with valid.
  - mismatch holds until the next DONE or reset.
- Disabled:
  - expect_din is unused and no latch register is synthesized.
  - mismatch is tied to 0.
  - Port list is unchanged.

Decomposition:
- Shared package sr_pkg:
  - SR_WIDTH=170 and SR_CNT_W=8, shared with the write controller.
  - State encoding enum: IDLE=0, WAIT=1, SHIFT=2, DONE=3.
- One natural sub-module: sr_deser, the WIDTH-bit serial-in parallel-out register with shift-enable and clear.
- The FSM, counters and compare stay in the top level.

Test Plan:
- Reset, then WIDTH=170, LATENCY=0, start pulse at edge k, dout_sr driving bits of 170'b1011 MSB-first -> valid pulse at edge k+171; dout=170'b1011; busy high edges k+1..k+171; count=170.
- LATENCY=3, same stream delayed 3 cycles -> dout=170'b1011; valid at edge k+174; dout_sr bits during WAIT have no effect.
- start re-pulsed at cycle k+50 during SHIFT -> ignored; single valid at k+171; dout correct.
- rst asserted at count=80 -> next edge: busy=0, count=0, dout=0, valid never pulses; a fresh start then completes normally.
- start held high for 400 cycles -> two completed captures, with valid pulses 172 cycles apart (LATENCY=0).
- With SR_READBACK_COMPARE_EN: expect_din=170'b1011 and matching stream -> mismatch=0; flip received bit 0 -> mismatch=1 with valid. Without the macro -> mismatch stays 0.
